// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
// Samples the asynchronous rxd line in the middle of each bit using a clock-divider
// bit timer. Frame shape is set by DATA_BITS, STOP_BITS and MSB_FIRST. Received words
// are handed to the consumer over a valid/ready handshake. Framing errors and overruns
// are reported as one-cycle pulses.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, a parity bit is
// expected after the data bits (even parity, or odd parity when PARITY_ODD=1) and
// parity_err is live. When it is undefined, no parity bit is expected and parity_err
// is tied to 0.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] word,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = 4;
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration time.
    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (MSB_FIRST != 0 && MSB_FIRST != 1) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_rx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Places one received bit into the word according to the configured bit order.
    function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] cur,
                                                      input logic              b);
        if (MSB_FIRST != 0) begin
            shift_in = {cur[DATA_BITS-2:0], b};
        end else begin
            shift_in = {b, cur[DATA_BITS-1:1]};
        end
    endfunction

`ifdef UART_RX_PARITY_EN
    // XOR reduction of the data word, used for the parity check.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        parity_of = ^d;
    endfunction
`endif

    logic                 sync1_r;
    logic                 rxd_s_r;
    state_t               state_r;
    state_t               state_s;
    logic [TW-1:0]        timer_r;
    logic [TW-1:0]        timer_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_s;
    logic                 stop_bad_r;
    logic                 stop_bad_s;
    logic                 stop_now_bad_s;
    logic                 done_r;
    logic                 done_s;
    logic                 ferr_s;
    logic                 frame_err_r;
    logic                 busy_r;
    logic [DATA_BITS-1:0] word_r;
    logic                 word_valid_r;
    logic                 overrun_r;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_r;
    logic                 par_bad_s;
    logic                 perr_s;
    logic                 parity_err_r;
`endif

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            rxd_s_r <= 1'b1;
        end else begin
            sync1_r <= rxd;
            rxd_s_r <= sync1_r;
        end
    end

    // Frame FSM: next state, bit timer, bit counter, shift register and error decisions.
    always_comb begin
        state_s        = state_r;
        timer_s        = timer_r;
        cnt_s          = cnt_r;
        shift_s        = shift_r;
        stop_bad_s     = stop_bad_r;
        stop_now_bad_s = stop_bad_r | ~rxd_s_r;
        done_s         = 1'b0;
        ferr_s         = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_s      = par_bad_r;
        perr_s         = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                timer_s    = {TW{1'b0}};
                cnt_s      = {CW{1'b0}};
                stop_bad_s = 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad_s  = 1'b0;
`endif
                if (!rxd_s_r) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_r == HALF_LAST) begin
                    timer_s = {TW{1'b0}};
                    if (rxd_s_r) begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_r == FULL_LAST) begin
                    timer_s = {TW{1'b0}};
                    shift_s = shift_in(shift_r, rxd_s_r);
                    if (cnt_r == DATA_LAST) begin
                        cnt_s = {CW{1'b0}};
`ifdef UART_RX_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        cnt_s = cnt_r + 1'b1;
                    end
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (timer_r == FULL_LAST) begin
                    timer_s   = {TW{1'b0}};
                    par_bad_s = ((parity_of(shift_r) ^ rxd_s_r) != (PARITY_ODD != 0));
                    state_s   = ST_STOP;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (timer_r == FULL_LAST) begin
                    timer_s = {TW{1'b0}};
                    if (cnt_r == STOP_LAST) begin
                        cnt_s = {CW{1'b0}};
                        if (stop_now_bad_s) begin
                            ferr_s  = 1'b1;
                            state_s = ST_BREAK;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (par_bad_r) begin
                            perr_s  = 1'b1;
                            state_s = ST_IDLE;
                        end
`endif
                        else begin
                            // Good frame: resync at mid-stop so a back-to-back start is caught.
                            done_s  = 1'b1;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        stop_bad_s = stop_now_bad_s;
                        cnt_s      = cnt_r + 1'b1;
                    end
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rxd_s_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = {TW{1'b0}};
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Frame FSM state, datapath and error-pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            timer_r     <= {TW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            stop_bad_r  <= 1'b0;
            done_r      <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            cnt_r       <= cnt_s;
            shift_r     <= shift_s;
            stop_bad_r  <= stop_bad_s;
            done_r      <= done_s;
            frame_err_r <= ferr_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch latch and parity error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            par_bad_r    <= par_bad_s;
            parity_err_r <= perr_s;
        end
    end
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    // Word delivery: hand a good frame to the consumer, or flag overrun if the old word is still unaccepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_r       <= {DATA_BITS{1'b0}};
            word_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (done_r) begin
                if (!word_valid_r || word_ready) begin
                    word_r       <= shift_r;
                    word_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (word_valid_r && word_ready) begin
                word_valid_r <= 1'b0;
            end else begin
                word_valid_r <= word_valid_r;
            end
        end
    end

    assign word       = word_r;
    assign word_valid = word_valid_r;
    assign busy       = busy_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;

endmodule
